// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, execute redirect and the
// valid/ready instruction hand-off to decode.
interface fetch_unit_if #(
    parameter int ADR_W = 16
);
    logic [ADR_W-1:0] i_mem_adr;
    logic             i_mem_rdy;
    logic [15:0]      i_mem_data;
    logic             redirect_valid;
    logic [ADR_W-1:0] redirect_adr;
    logic             instr_valid;
    logic             instr_ready;
    logic [15:0]      instr_data;
    logic [ADR_W-1:0] instr_pc;

    modport master (
        output i_mem_adr,
        input  i_mem_rdy,
        input  i_mem_data,
        input  redirect_valid,
        input  redirect_adr,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  i_mem_adr,
        output i_mem_rdy,
        output i_mem_data,
        output redirect_valid,
        output redirect_adr,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the fetch address, buffers returned words with
// their PC in a prefetch FIFO and hands them to decode; redirects flush and restart.
module fetch_unit #(
    parameter int               ADR_W    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [ADR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          a_rst,
    fetch_unit_if.master  bus
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [ADR_W-1:0] pc_r;
    logic [ADR_W-1:0] pc_mem_r   [DEPTH];
    logic [15:0]      data_mem_r [DEPTH];
    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic [PW:0]      count_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             last_slot_s;

    // Occupancy flags decoded from the wrap-bit pointers.
    always_comb begin
        count_s     = wr_ptr_r - rd_ptr_r;
        empty_s     = (wr_ptr_r == rd_ptr_r);
        full_s      = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                      (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
        last_slot_s = (count_s == (PW+1)'(DEPTH-1));
        // A redirect suppresses the push; the pop still counts as consumed by decode.
        push_s      = (state_r == ST_FETCH) && bus.i_mem_rdy && !full_s && !bus.redirect_valid;
        pop_s       = !empty_s && bus.instr_ready;
    end

    // Next-state decode for the fetch sequencer.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.redirect_valid) begin
            state_nxt_s = ST_REDIR;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (push_s && last_slot_s && !pop_s) begin
                        state_nxt_s = ST_STALL;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_STALL: begin
                    if (pop_s) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_STALL;
                    end
                end
                ST_REDIR: state_nxt_s = ST_FETCH;
                default:  state_nxt_s = ST_FETCH;
            endcase
        end
    end

    // PC, FIFO storage and pointer update; redirect flushes by collapsing rd onto wr.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_r  <= ST_FETCH;
            pc_r     <= RESET_PC;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= '0;
                data_mem_r[i] <= 16'h0000;
            end
        end else begin
            state_r <= state_nxt_s;
            if (bus.redirect_valid) begin
                pc_r     <= bus.redirect_adr & ~ADR_W'(1'b1);
                rd_ptr_r <= wr_ptr_r;
            end else begin
                if (push_s) begin
                    pc_mem_r[wr_ptr_r[PW-1:0]]   <= pc_r;
                    data_mem_r[wr_ptr_r[PW-1:0]] <= bus.i_mem_data;
                    wr_ptr_r                     <= wr_ptr_r + (PW+1)'(1'b1);
                    pc_r                         <= pc_r + ADR_W'(2'd2);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + (PW+1)'(1'b1);
                end
            end
        end
    end

    assign bus.i_mem_adr   = pc_r;
    assign bus.instr_valid = !empty_s;
    assign bus.instr_data  = data_mem_r[rd_ptr_r[PW-1:0]];
    assign bus.instr_pc    = pc_mem_r[rd_ptr_r[PW-1:0]];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, half-rate memory,
// redirects, PC wrap and asynchronous reset during a stall.
module tb_fetch_unit;
    logic clk;
    logic a_rst;
    int   vec_cnt;
    int   err_cnt;

    fetch_unit_if #(.ADR_W(16)) bus ();

    fetch_unit #(.ADR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    // Memory model: word is a fixed scramble of its address so data and pc differ.
    assign bus.i_mem_data = bus.i_mem_adr ^ 16'hA5A5;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] exp_pc);
        chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        chk({tag, "_pc"},    {16'd0, bus.instr_pc},    {16'd0, exp_pc});
        chk({tag, "_data"},  {16'd0, bus.instr_data},  {16'd0, exp_pc ^ 16'hA5A5});
    endtask

    task automatic do_redirect(input logic [15:0] adr, input logic rdy, input logic rdyq);
        bus.redirect_valid = 1'b1;
        bus.redirect_adr   = adr;
        bus.i_mem_rdy      = rdy;
        bus.instr_ready    = rdyq;
        cyc();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] prev_adr;
        int          n;
        vec_cnt = 0;
        err_cnt = 0;
        a_rst              = 1'b0;
        bus.i_mem_rdy      = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_adr   = 16'h0000;

        // Reset and stream
        cyc();
        cyc();
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_adr",   {16'd0, bus.i_mem_adr},   32'h0000);
        chk("rst_data",  {16'd0, bus.instr_data},  32'h0000);
        chk("rst_pc",    {16'd0, bus.instr_pc},    32'h0000);
        a_rst           = 1'b1;
        bus.i_mem_rdy   = 1'b1;
        bus.instr_ready = 1'b1;
        chk("stream_pre_valid", {31'd0, bus.instr_valid}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("stream_adr", {16'd0, bus.i_mem_adr}, 32'(2 * k));
            chk_head("stream", 16'(2 * (k - 1)));
        end

        // Backpressure until full, then drain in order
        do_redirect(16'h0000, 1'b0, 1'b0);
        chk("bp_flush_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("bp_flush_adr",   {16'd0, bus.i_mem_adr},   32'h0000);
        bus.i_mem_rdy = 1'b1;
        cyc();
        chk("bp_redir_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("bp_redir_adr",   {16'd0, bus.i_mem_adr},   32'h0000);
        for (int k = 0; k < 4; k++) cyc();
        chk("bp_full_adr", {16'd0, bus.i_mem_adr}, 32'h0008);
        chk_head("bp_full", 16'h0000);
        cyc();
        cyc();
        chk("bp_stall_adr", {16'd0, bus.i_mem_adr}, 32'h0008);
        bus.instr_ready = 1'b1;
        exp_pc = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            chk_head("bp_drain", exp_pc);
            exp_pc = exp_pc + 16'd2;
            cyc();
            if (k == 0) chk("bp_resume_adr", {16'd0, bus.i_mem_adr}, 32'h0008);
        end

        // Half-rate memory
        do_redirect(16'h0100, 1'b0, 1'b1);
        cyc();
        exp_pc = 16'h0100;
        n = 0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            if (bus.instr_valid) begin
                chk_head("hr", exp_pc);
                exp_pc = exp_pc + 16'd2;
                n++;
            end
            bus.i_mem_rdy = (i % 2 == 0) ? 1'b1 : 1'b0;
            prev_adr = bus.i_mem_adr;
            cyc();
            chk("hr_adr", {16'd0, bus.i_mem_adr},
                {16'd0, bus.i_mem_rdy ? prev_adr + 16'd2 : prev_adr});
        end
        chk("hr_count", 32'(n), 32'd10);

        // Redirect mid-stream with FIFO holding 4,6
        do_redirect(16'h0004, 1'b0, 1'b0);
        cyc();
        bus.i_mem_rdy = 1'b1;
        cyc();
        cyc();
        chk_head("mid_pre", 16'h0004);
        chk("mid_pre_adr", {16'd0, bus.i_mem_adr}, 32'h0008);
        do_redirect(16'h0041, 1'b1, 1'b0);
        chk("mid_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mid_adr",   {16'd0, bus.i_mem_adr},   32'h0040);
        cyc();
        chk("mid_discard_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mid_discard_adr",   {16'd0, bus.i_mem_adr},   32'h0040);
        bus.instr_ready = 1'b1;
        cyc();
        chk_head("mid_first", 16'h0040);
        chk("mid_first_adr", {16'd0, bus.i_mem_adr}, 32'h0042);

        // Redirect coincident with push and pop
        do_redirect(16'h0200, 1'b1, 1'b1);
        chk("co_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("co_adr",   {16'd0, bus.i_mem_adr},   32'h0200);
        cyc();
        chk("co_redir_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("co_redir_adr",   {16'd0, bus.i_mem_adr},   32'h0200);
        cyc();
        chk_head("co_first", 16'h0200);
        chk("co_first_adr", {16'd0, bus.i_mem_adr}, 32'h0202);

        // PC wrap, then async reset while stalled
        do_redirect(16'hFFFC, 1'b1, 1'b1);
        chk("wr_adr0", {16'd0, bus.i_mem_adr}, 32'hFFFC);
        cyc();
        cyc();
        chk_head("wr_h0", 16'hFFFC);
        chk("wr_adr1", {16'd0, bus.i_mem_adr}, 32'hFFFE);
        cyc();
        chk_head("wr_h1", 16'hFFFE);
        chk("wr_adr2", {16'd0, bus.i_mem_adr}, 32'h0000);
        cyc();
        chk_head("wr_h2", 16'h0000);
        chk("wr_adr3", {16'd0, bus.i_mem_adr}, 32'h0002);
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        chk("wr_stall_adr", {16'd0, bus.i_mem_adr}, 32'h0008);
        chk_head("wr_stall", 16'h0000);
        #2;
        a_rst = 1'b0;
        #1;
        chk("ar_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("ar_adr",   {16'd0, bus.i_mem_adr},   32'h0000);
        chk("ar_data",  {16'd0, bus.instr_data},  32'h0000);
        chk("ar_pc",    {16'd0, bus.instr_pc},    32'h0000);
        cyc();
        a_rst = 1'b1;
        cyc();
        chk_head("ar_restart", 16'h0000);
        chk("ar_restart_adr", {16'd0, bus.i_mem_adr}, 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
